// File: rtl/conv3x3_seq_ctrl.sv
// conv3x3_seq_ctrl
// Frame-level sequencer and configurator for the 3x3 convolution MAC.
// Holds the nine signed kernel coefficients, accepts a raster pixel stream,
// advances the line buffer, enables the MAC, tags every real window so its
// result on conv_out is flagged with output coordinates, and flushes the MAC
// pipeline at end of frame.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   cfg_we/addr/data  coefficient write (index 3*row+col, 0..8), IDLE only
//   cfg_err           one-cycle pulse after a rejected write
//   k_flat            coefficients, k00 at [7:0] ... k22 at [71:64]
//   start             begin a frame (only looked at in IDLE)
//   busy, done        frame in progress / one-cycle end-of-frame pulse
//   in_valid/in_ready pixel handshake
//   lb_shift          line buffer advance (pixel accepted)
//   mac_en            MAC pixel_valid
//   res_valid/row/col conv_out holds a real result and its output coordinate
module conv3x3_seq_ctrl #(
  parameter int IMG_W   = 28,
  parameter int IMG_H   = 28,
  parameter int MAC_LAT = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cfg_we,
  input  logic [3:0]               cfg_addr,
  input  logic [7:0]               cfg_data,
  output logic                     cfg_err,
  output logic [71:0]              k_flat,
  input  logic                     start,
  output logic                     busy,
  output logic                     done,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic                     lb_shift,
  output logic                     mac_en,
  output logic                     res_valid,
  output logic [$clog2(IMG_H)-1:0] res_row,
  output logic [$clog2(IMG_W)-1:0] res_col
);

  localparam int RW = $clog2(IMG_H);
  localparam int CW = $clog2(IMG_W);
  localparam int FW = $clog2(MAC_LAT + 1);

  typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

  state_t         state, state_nxt;
  logic [RW-1:0]  row;
  logic [CW-1:0]  col;
  logic [FW-1:0]  flush_cnt;
  logic           accept;
  logic           win;
  logic           last_pix;
  logic           cfg_ok;

  // One tag per MAC pipeline stage; a tag travels with its window so the
  // result can be identified when it emerges.
  logic           tag_v [MAC_LAT];
  logic [RW-1:0]  tag_r [MAC_LAT];
  logic [CW-1:0]  tag_c [MAC_LAT];

  // A full 3x3 window exists once two rows and two columns are behind us.
  assign win      = (row >= RW'(2)) && (col >= CW'(2));
  assign last_pix = (row == RW'(IMG_H - 1)) && (col == CW'(IMG_W - 1));
  assign lb_shift = accept;
  assign cfg_ok   = cfg_we && (state == IDLE) && (cfg_addr <= 4'd8);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state and handshake/strobe decode.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    mac_en    = 1'b0;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nxt = RUN;
      end
      RUN: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        accept   = in_valid;
        mac_en   = in_valid && win;
        if (in_valid && last_pix) state_nxt = FLUSH;
      end
      FLUSH: begin
        busy   = 1'b1;
        mac_en = 1'b1;
        if (flush_cnt == FW'(1)) state_nxt = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Raster position of the pixel currently offered, and flush countdown.
  always_ff @(posedge clk) begin
    if (rst) begin
      row       <= '0;
      col       <= '0;
      flush_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            row <= '0;
            col <= '0;
          end
        end
        RUN: begin
          if (accept) begin
            if (col == CW'(IMG_W - 1)) begin
              col <= '0;
              if (row == RW'(IMG_H - 1)) begin
                row       <= '0;
                flush_cnt <= FW'(MAC_LAT);
              end else begin
                row <= row + RW'(1);
              end
            end else begin
              col <= col + CW'(1);
            end
          end
        end
        FLUSH: flush_cnt <= flush_cnt - FW'(1);
        default: ;
      endcase
    end
  end

  // Tag pipeline moves only when the MAC advances; flush enables push
  // invalid tags so they never produce a result flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < MAC_LAT; i++) begin
        tag_v[i] <= 1'b0;
        tag_r[i] <= '0;
        tag_c[i] <= '0;
      end
    end else if (mac_en) begin
      tag_v[0] <= (state == RUN);
      tag_r[0] <= row - RW'(2);
      tag_c[0] <= col - CW'(2);
      for (int i = 1; i < MAC_LAT; i++) begin
        tag_v[i] <= tag_v[i-1];
        tag_r[i] <= tag_r[i-1];
        tag_c[i] <= tag_c[i-1];
      end
    end
  end

  // Result flag is registered from the tag leaving the pipeline so it lines
  // up with the MAC's registered conv_out.
  always_ff @(posedge clk) begin
    if (rst) begin
      res_valid <= 1'b0;
      res_row   <= '0;
      res_col   <= '0;
    end else if (mac_en) begin
      res_valid <= tag_v[MAC_LAT-1];
      res_row   <= tag_r[MAC_LAT-1];
      res_col   <= tag_c[MAC_LAT-1];
    end else begin
      res_valid <= 1'b0;
    end
  end

  // Coefficient registers; writes are only honoured while idle so a frame
  // never sees its kernel change underneath it.
  always_ff @(posedge clk) begin
    if (rst) begin
      k_flat  <= '0;
      cfg_err <= 1'b0;
    end else begin
      cfg_err <= cfg_we && !cfg_ok;
      for (int i = 0; i < 9; i++) begin
        if (cfg_ok && (cfg_addr == 4'(i))) k_flat[i*8 +: 8] <= cfg_data;
      end
    end
  end

endmodule

// File: tb/tb_conv3x3_seq_ctrl.sv
// tb_conv3x3_seq_ctrl
// Self-checking bench for conv3x3_seq_ctrl (4x4 frame, MAC_LAT=2).
// A driver issues frames and coefficient writes; the expected output
// coordinates of each frame are queued when the frame is started and a
// negedge monitor pops them as results appear. The monitor also keeps a
// frame-level reference (accepted pixel count, flush length, kernel image).
module tb_conv3x3_seq_ctrl;

  localparam int W    = 4;
  localparam int H    = 4;
  localparam int LAT  = 2;
  localparam int PIX  = W * H;
  localparam int NRES = (W - 2) * (H - 2);

  localparam logic [31:0] EXP_MAC = (32'd1 << 11) | (32'd1 << 12) | (32'd1 << 15) |
                                    (32'd1 << 16) | (32'd1 << 17) | (32'd1 << 18);
  localparam logic [31:0] EXP_RES = 32'h000F_0000;
  localparam logic [31:0] EXP_ACC = 32'h0001_FFFE;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cfg_we = 1'b0;
  logic [3:0]  cfg_addr = 4'd0;
  logic [7:0]  cfg_data = 8'd0;
  logic        start = 1'b0;
  logic        in_valid = 1'b0;
  logic        cfg_err, busy, done, in_ready, lb_shift, mac_en, res_valid;
  logic [71:0] k_flat;
  logic [1:0]  res_row, res_col;

  typedef struct {
    int row;
    int col;
  } coord_t;

  coord_t      sb[$];
  coord_t      exp_c;
  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  int          start_cyc = 0;
  bit          exact_mode = 1'b0;

  // Reference model state.
  bit          m_run = 1'b0;
  bit          m_done = 1'b0;
  bit          m_err = 1'b0;
  int          m_flush = 0;
  int          m_acc = 0;
  int          m_res = 0;
  int          m_mac = 0;
  logic [71:0] k_model = '0;
  logic [31:0] mac_mask = '0;
  logic [31:0] res_mask = '0;
  logic [31:0] acc_mask = '0;
  logic        exp_ready, exp_shift, exp_mac, exp_busy;
  int          rel;

  conv3x3_seq_ctrl #(.IMG_W(W), .IMG_H(H), .MAC_LAT(LAT)) dut (
    .clk(clk), .rst(rst),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .cfg_err(cfg_err), .k_flat(k_flat),
    .start(start), .busy(busy), .done(done),
    .in_valid(in_valid), .in_ready(in_ready), .lb_shift(lb_shift),
    .mac_en(mac_en), .res_valid(res_valid), .res_row(res_row), .res_col(res_col)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [71:0] act, input logic [71:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h required %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic failNow(input string name);
    total++;
    bad++;
    $display("[TB] FAIL %s: bound expired (cycle %0d)", name, cyc);
  endtask

  // Monitor / scoreboard: checks every cycle against the frame-level model.
  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      m_run   = 1'b0;
      m_done  = 1'b0;
      m_err   = 1'b0;
      m_flush = 0;
      m_acc   = 0;
      k_model = '0;
      sb.delete();
    end else begin
      exp_busy  = m_run || (m_flush > 0) || m_done;
      exp_ready = m_run;
      exp_shift = in_valid && exp_ready;
      if (exp_shift) exp_mac = ((m_acc / W) >= 2) && ((m_acc % W) >= 2);
      else           exp_mac = (m_flush > 0);

      checkOutput("in_ready", in_ready, exp_ready);
      checkOutput("lb_shift", lb_shift, exp_shift);
      checkOutput("mac_en", mac_en, exp_mac);
      checkOutput("busy", busy, exp_busy);
      checkOutput("done", done, m_done);
      checkOutput("cfg_err", cfg_err, m_err);
      checkOutput("k_flat", k_flat, k_model);
      if (mac_en) m_mac++;

      rel = cyc - start_cyc;
      if (exact_mode && rel >= 0 && rel < 32) begin
        if (mac_en)    mac_mask[rel] = 1'b1;
        if (res_valid) res_mask[rel] = 1'b1;
        if (lb_shift)  acc_mask[rel] = 1'b1;
      end

      if (res_valid) begin
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("[TB] FAIL res_unexpected: got res_valid=1 (%0d,%0d) required none (cycle %0d)",
                   res_row, res_col, cyc);
        end else begin
          exp_c = sb.pop_front();
          checkOutput("res_row", res_row, exp_c.row);
          checkOutput("res_col", res_col, exp_c.col);
          m_res++;
        end
      end

      m_err = cfg_we && (exp_busy || cfg_addr > 4'd8);
      if (cfg_we && !exp_busy && cfg_addr <= 4'd8) k_model[int'(cfg_addr)*8 +: 8] = cfg_data;

      if (m_done) begin
        checkOutput("frame_results", m_res, NRES);
        checkOutput("frame_mac_en", m_mac, NRES + LAT);
        checkOutput("sb_leftover", sb.size(), 0);
        if (exact_mode) begin
          checkOutput("done_cycle", rel, 19);
          checkOutput("mac_en_cycles", mac_mask, EXP_MAC);
          checkOutput("res_valid_cycles", res_mask, EXP_RES);
          checkOutput("accept_cycles", acc_mask, EXP_ACC);
        end
        m_done = 1'b0;
      end else if (m_flush > 0) begin
        m_flush--;
        if (m_flush == 0) m_done = 1'b1;
      end else if (m_run) begin
        if (exp_shift) begin
          m_acc++;
          if (m_acc == PIX) begin
            m_run   = 1'b0;
            m_flush = LAT;
          end
        end
      end else if (start) begin
        m_run     = 1'b1;
        m_acc     = 0;
        m_res     = 0;
        m_mac     = 0;
        start_cyc = cyc;
        mac_mask  = '0;
        res_mask  = '0;
        acc_mask  = '0;
      end
    end
  end

  // Runs one frame. valid_mode: 0 held high, 1 toggling, 2 random.
  task automatic applyStimulus(input int valid_mode, input int abort_after,
                               input bit poke_start, input bit run_cfg, input bit exact);
    int accepted = 0;
    int guard = 0;
    int waitc = 0;
    exact_mode = exact;
    start    = 1'b1;
    cfg_we   = 1'b1;
    cfg_addr = 4'd8;
    cfg_data = 8'($urandom);
    for (int r = 0; r < H - 2; r++)
      for (int c = 0; c < W - 2; c++) sb.push_back('{r, c});
    @(posedge clk); #1;
    start  = 1'b0;
    cfg_we = 1'b0;
    while (accepted < PIX && guard < 400) begin
      case (valid_mode)
        0:       in_valid = 1'b1;
        1:       in_valid = (guard % 2 == 0);
        default: in_valid = ($urandom_range(0, 3) != 0);
      endcase
      start    = poke_start && (accepted == 5);
      cfg_we   = run_cfg && (accepted == 3);
      cfg_addr = 4'($urandom_range(0, 8));
      cfg_data = 8'($urandom);
      if (in_valid && in_ready) accepted++;
      @(posedge clk); #1;
      guard++;
      if (abort_after > 0 && accepted == abort_after) begin
        in_valid = 1'b0;
        start    = 1'b0;
        cfg_we   = 1'b0;
        rst      = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        return;
      end
    end
    in_valid = 1'b0;
    start    = 1'b0;
    cfg_we   = 1'b0;
    if (accepted < PIX) failNow("accept_timeout");
    while (!done && waitc < 40) begin
      @(posedge clk); #1;
      waitc++;
    end
    if (!done) failNow("done_timeout");
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_in_ready", in_ready, 0);
    checkOutput("rst_lb_shift", lb_shift, 0);
    checkOutput("rst_mac_en", mac_en, 0);
    checkOutput("rst_res_valid", res_valid, 0);
    checkOutput("rst_res_row", res_row, 0);
    checkOutput("rst_res_col", res_col, 0);
    checkOutput("rst_cfg_err", cfg_err, 0);
    checkOutput("rst_k_flat", k_flat, 0);
    rst = 1'b0;
    idle(1);

    cfg_we = 1'b1; cfg_addr = 4'd4; cfg_data = 8'hFD;
    @(posedge clk); #1;
    cfg_we = 1'b0;
    checkOutput("k11_write", k_flat[39:32], 8'hFD);
    checkOutput("cfg_err_good_addr", cfg_err, 0);
    cfg_we = 1'b1; cfg_addr = 4'd9; cfg_data = 8'h55;
    @(posedge clk); #1;
    cfg_we = 1'b0;
    checkOutput("cfg_err_addr9", cfg_err, 1);
    checkOutput("k_after_addr9", k_flat, {32'h0, 8'hFD, 32'h0});
    @(posedge clk); #1;
    checkOutput("cfg_err_clears", cfg_err, 0);

    repeat (12) begin
      cfg_we   = 1'($urandom_range(0, 1));
      cfg_addr = 4'($urandom_range(0, 15));
      cfg_data = 8'($urandom);
      @(posedge clk); #1;
    end
    cfg_we = 1'b0;
    idle(2);

    applyStimulus(0, 0, 1'b0, 1'b0, 1'b1);
    idle(3);
    applyStimulus(1, 0, 1'b0, 1'b1, 1'b0);
    idle(3);
    applyStimulus(2, 0, 1'b1, 1'b0, 1'b0);
    idle(3);
    applyStimulus(0, 9, 1'b0, 1'b0, 1'b0);
    idle(20);
    applyStimulus(0, 0, 1'b0, 1'b0, 1'b1);
    idle(5);
    applyStimulus(2, 0, 1'b0, 1'b1, 1'b0);
    idle(5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/conv3x3_seq_ctrl.md
Name: conv3x3_seq_ctrl

Overview:
Frame-level sequencer and configurator for the 3x3 convolution MAC. It holds the nine signed kernel coefficients, which are loaded through a register-write port, and accepts a raster pixel stream with a valid/ready handshake. It generates the line-buffer shift strobe and the MAC enable (pixel_valid). It tracks the MAC's enable-advanced pipeline so each real convolution result is flagged with its output coordinates, and it flushes the pipeline at end of frame.

Parameters:
IMG_W, 28, input frame width in pixels (>=3)
IMG_H, 28, input frame height in pixels (>=3)
MAC_LAT, 2, number of MAC enables between issuing a window and its result appearing on conv_out (>=1)

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
cfg_we  in  1  kernel register write strobe
cfg_addr  in  4  coefficient index, 3*row+col (0..8)
cfg_data  in  8  signed coefficient
cfg_err  out  1  one-cycle pulse: write rejected (busy or addr>8)
k_flat  out  72  coefficients, k00 at [7:0] ... k22 at [71:64]
start  in  1  begin frame (sampled in IDLE only)
busy  out  1  high in RUN/FLUSH/DONE
done  out  1  one-cycle pulse in DONE
in_valid  in  1  pixel available from source
in_ready  out  1  controller accepts pixel
lb_shift  out  1  line buffer advance (= in_valid & in_ready)
mac_en  out  1  drives MAC pixel_valid
res_valid  out  1  conv_out holds a real result this cycle
res_row  out  clog2(IMG_H)  output row of result (0..IMG_H-3)
res_col  out  clog2(IMG_W)  output col of result (0..IMG_W-3)

Behaviour:
- Reset: state IDLE; all outputs 0; k_flat 0; counters and tag pipeline cleared. Reset mid-frame aborts immediately and emits no done.
- cfg write in IDLE with addr<=8: coefficient updated at that edge; cfg_err 0. Write while busy or with addr>8: ignored, cfg_err=1 in the next cycle.
- start and cfg_we in the same IDLE cycle: the write lands and the frame uses the new value.
- IDLE: in_ready=0. start=1 -> RUN next cycle with row=col=0. start while busy is ignored.
- RUN: in_ready=1. accept=in_valid&in_ready. lb_shift=accept (combinational).
- In RUN, mac_en = accept & row>=2 & col>=2 (combinational).
- On accept, col increments; col wraps at IMG_W-1 to 0 with row+1. in_valid low stalls: no counter change, no mac_en.
- Accepting the pixel at (IMG_H-1, IMG_W-1) -> FLUSH, flush_cnt=MAC_LAT.
- FLUSH: in_ready=0; mac_en=1 every cycle for MAC_LAT cycles -> DONE.
- DONE: done=1, busy=1 for one cycle -> IDLE.
- Tag pipeline: MAC_LAT entries of {valid,row-2,col-2}, shifted only on mac_en. The entry inserted is valid for window enables and invalid for flush enables.
- On mac_en, res_valid/res_row/res_col are registered from the entry shifted out; otherwise res_valid <= 0. This aligns res_valid with conv_out.
- Result count per frame is exactly (IMG_W-2)*(IMG_H-2). mac_en count is that plus MAC_LAT.

Test Plan:
- Reset values: assert rst 3 cycles -> all outputs 0, k_flat=0, in_ready=0.
- Config: write addr 4 = -3 (0xFD), then addr 9 -> k_flat[39:32]=0xFD; cfg_err pulses only for addr 9. Write during RUN -> cfg_err=1, k_flat unchanged.
- Full frame, IMG_W=IMG_H=4, MAC_LAT=2, in_valid held high, start in cycle 0:
  - pixels accepted cycles 1..16;
  - mac_en in cycles 11,12,15,16,17,18;
  - res_valid in cycles 16,17,18,19 with (row,col) = (0,0),(0,1),(1,0),(1,1);
  - done in cycle 19; IDLE in cycle 20.
- Backpressure: same frame with in_valid toggled 1/0 -> 4 results, identical coordinates, no mac_en in stalled cycles, no lb_shift while in_valid=0.
- Abort: rst asserted after 9 accepted pixels -> IDLE, no done, no res_valid. A subsequent start runs a clean frame matching the full-frame test.
- Start ignored: start pulsed during RUN -> frame unaffected, single done.
